// File: rtl/ram_reader.sv
// ram_reader -- read-side master for a single-port RAM.
//
// On a start command the block walks `count` consecutive RAM addresses,
// beginning at `start_address`. The address wraps modulo 2**ADDRESS_BITS.
// The words read are emitted on a valid/ready stream. A 2-entry output FIFO
// absorbs the RAM's 1-cycle registered read latency and downstream
// back-pressure, so the block sustains one word per cycle while out_ready is
// held high.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          command strobe, sampled only while idle
//   start_address  first address of the block
//   count          words to read, 0..2**ADDRESS_BITS (0 is ignored)
//   busy           high while a block is in progress (registered)
//   done           one-cycle pulse after the last word is accepted
//   ram_enable     RAM write enable, tied low (read-only master)
//   ram_address    address presented to the RAM
//   ram_data_out   RAM read data, valid one cycle after the address is sampled
//   out_valid      out_data holds a word
//   out_ready      consumer accepts the word when out_valid && out_ready
//   out_data       stream data (FIFO head)
module ram_reader #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] start_address,
  input  logic [ADDRESS_BITS:0]   count,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  input  logic [DATA_BITS-1:0]    ram_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_BITS-1:0]    out_data
);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a start command
    S_READ,   // reads remain to be issued
    S_DRAIN   // all reads issued; waiting for the FIFO and in-flight read to empty
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [ADDRESS_BITS:0]   issue_left_q, issue_left_d;
  logic [ADDRESS_BITS:0]   words_left_q, words_left_d;
  logic                    inflight_q, inflight_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Two-entry FIFO. When the FIFO is full, rd_ptr_q equals wr_ptr_q.
  logic [DATA_BITS-1:0]    fifo_q [2];
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              occ_q, occ_d;

  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [2:0]              pending;

  assign ram_enable  = 1'b0;
  assign ram_address = addr_q;
  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;

  // A read issued at the previous edge returns its data now.
  assign push    = inflight_q;
  assign pop     = out_valid && out_ready;
  // Words held in the FIFO plus the read in flight. A new read is issued
  // only if its word is guaranteed a FIFO slot when it returns. That is the
  // case when pending - pop < 2, rewritten here as pending < 2 + pop.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue   = (state_q == S_READ) && (pending < (3'd2 + {2'b00, pop}));

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // case statement leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    words_left_d = words_left_q;
    inflight_d   = issue;
    done_d       = 1'b0;
    occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d     = rd_ptr_q ^ pop;
    wr_ptr_d     = wr_ptr_q ^ push;

    unique case (state_q)
      S_IDLE: begin
        if (start && (count != '0)) begin
          addr_d       = start_address;
          issue_left_d = count;
          words_left_d = count;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d       = addr_q + ADDRESS_BITS'(1);
          issue_left_d = issue_left_q - (ADDRESS_BITS + 1)'(1);
          if (issue_left_q == (ADDRESS_BITS + 1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    // The block completes when its last word handshakes. The same edge
    // returns the FSM to idle, so a new start is accepted while done is high.
    if (pop && (state_q != S_IDLE)) begin
      words_left_d = words_left_q - (ADDRESS_BITS + 1)'(1);
      if (words_left_q == (ADDRESS_BITS + 1)'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
    end
  end

  // NOTE: the FIFO storage is cleared on reset so that out_data reads 0 after
  // reset. The two entries cost little to reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= ram_data_out;
    end
  end

endmodule
